// File: rtl/iob_fifo_unpack_reader_pkg.sv
// Shared constants and helpers for the FIFO read-side unpacker and
// the matching write-side packer of the asymmetric FIFO.
package iob_fifo_unpack_reader_pkg;

    // Cycles between the FIFO read strobe and valid read data.
    localparam int FIFO_RD_LAT = 1;

    // Order in which the narrow lanes of a wide word are streamed.
    typedef enum logic {
        LANE_LOW_FIRST  = 1'b0,
        LANE_HIGH_FIRST = 1'b1
    } lane_order_t;

    localparam lane_order_t LANE_ORDER = LANE_LOW_FIRST;

    // Number of output lanes in one FIFO word.
    function automatic int calc_ratio(input int data_w, input int out_w);
        return data_w / out_w;
    endfunction

    // Lane index width; kept at least one bit so RATIO=1 still has a register.
    function automatic int calc_lane_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/iob_fifo_unpack_reader_skid2.sv
// Two-entry word queue between the FIFO read port and the lane splitter.
// The head register always holds the oldest word; push and pop may coincide.
module iob_word_skid2 #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_count;

    // Queue storage and occupancy; flush drops both entries.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b11: begin
                    // Occupancy stays the same; new word goes behind what remains.
                    if (r_count == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= i_data;
                    end else begin
                        r_tail <= i_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/iob_fifo_unpack_reader.sv
// Read-side engine for the synchronous FIFOs: fetches wide words with a
// one-cycle read latency and streams them out as narrow lanes on valid/ready.
module iob_fifo_unpack_reader
    import iob_fifo_unpack_reader_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              fifo_empty,
    output logic              fifo_read_en,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last_lane,
    output logic [CNT_W-1:0]  beat_cnt
);

    localparam int RATIO  = calc_ratio(DATA_W, OUT_W);
    localparam int LANE_W = calc_lane_w(RATIO);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    if ((DATA_W % OUT_W) != 0 || DATA_W < OUT_W) begin : g_bad_width
        $error("iob_fifo_unpack_reader: DATA_W must be a positive multiple of OUT_W");
    end

    // The single in-flight flag below only covers a one-cycle read port.
    if (FIFO_RD_LAT != 1) begin : g_bad_latency
        $error("iob_fifo_unpack_reader: only a read latency of 1 is supported");
    end

    logic              r_inflight;
    logic [LANE_W-1:0] r_lane;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic [DATA_W-1:0] w_head;
    logic [1:0]        w_count;
    logic              w_last;
    logic              w_xfer;
    logic              w_pop;
    logic              w_capture;
    logic [2:0]        w_pending;
    logic [LANE_W-1:0] w_lane_sel;

    iob_word_skid2 #(
        .W (DATA_W)
    ) u_skid (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_flush (flush),
        .i_push  (w_capture),
        .i_data  (fifo_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign out_valid = (w_count != 2'd0);
    assign w_last    = (r_lane == LAST_LANE);
    assign w_xfer    = out_valid && out_ready;
    assign w_pop     = w_xfer && w_last;

    // Words buffered plus in flight after this edge, crediting a pop happening now
    // so a RATIO=1 stream can refill every cycle without bubbles.
    assign w_pending = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // Gated by reset so no strobe leaks out while the block is held in reset.
    assign fifo_read_en = rst && !fifo_empty && !flush && (w_pending < 3'd2);

    // A flush in the cycle the data arrives discards that word.
    assign w_capture = r_inflight && !flush;

    assign w_lane_sel    = (LANE_ORDER == LANE_LOW_FIRST) ? r_lane : (LAST_LANE - r_lane);
    assign out_data      = w_head[int'(w_lane_sel) * OUT_W +: OUT_W];
    assign out_last_lane = out_valid && w_last;
    assign beat_cnt      = r_beat_cnt;

    // Read-in-flight tracking and lane position within the head word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= 1'b0;
            r_lane     <= '0;
        end else if (flush) begin
            r_inflight <= 1'b0;
            r_lane     <= '0;
        end else begin
            r_inflight <= fifo_read_en;
            if (w_xfer) begin
                r_lane <= w_last ? '0 : r_lane + LANE_W'(1);
            end
        end
    end

    // Accepted-beat counter; survives flush and wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat_cnt <= '0;
        end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_iob_fifo_unpack_reader.sv
// Bench for iob_fifo_unpack_reader: one 32->8 instance and one 8->8 instance,
// each fed by a queue-based FIFO model and checked against an expected-lane queue.
module tb_iob_fifo_unpack_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush [2];
    logic        ready [2];
    logic        empty [2];
    logic        rd_en [2];
    logic        vld   [2];
    logic        last  [2];
    logic [31:0] fdata [2];
    logic [7:0]  odata [2];
    logic [31:0] bcnt  [2];

    iob_fifo_unpack_reader #(.DATA_W(32), .OUT_W(8), .CNT_W(32)) dut_a (
        .clk           (clk),
        .rst           (rst_n),
        .flush         (flush[0]),
        .fifo_empty    (empty[0]),
        .fifo_read_en  (rd_en[0]),
        .fifo_data     (fdata[0]),
        .out_valid     (vld[0]),
        .out_ready     (ready[0]),
        .out_data      (odata[0]),
        .out_last_lane (last[0]),
        .beat_cnt      (bcnt[0])
    );

    iob_fifo_unpack_reader #(.DATA_W(8), .OUT_W(8), .CNT_W(32)) dut_b (
        .clk           (clk),
        .rst           (rst_n),
        .flush         (flush[1]),
        .fifo_empty    (empty[1]),
        .fifo_read_en  (rd_en[1]),
        .fifo_data     (fdata[1][7:0]),
        .out_valid     (vld[1]),
        .out_ready     (ready[1]),
        .out_data      (odata[1]),
        .out_last_lane (last[1]),
        .beat_cnt      (bcnt[1])
    );

    // Model state
    logic [31:0] fq      [2][$];
    logic [8:0]  exq     [2][$];
    logic [7:0]  obs     [2][$];
    logic        obs_lst [2][$];
    int          xcyc    [2][$];
    logic        force_empty [2];
    logic        pend_rd   [2];
    logic [31:0] pend_word [2];
    logic [31:0] beats     [2];
    int          wait_cnt  [2];
    int          rd_pulses [2];
    int          first_rd  [2];
    int          first_vld [2];
    logic        stall_prev [2];
    logic [7:0]  stall_data [2];
    int          cyc;
    int          n_checks;
    int          n_fail;

    function automatic int ratio_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic chk_eq(input string name, input longint act, input longint expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_step(input int d);
        int         r;
        logic [31:0] w;
        logic [8:0]  e;
        r = ratio_of(d);
        if (!rst_n) begin
            chk_eq("rst_rd_en", rd_en[d], 0);
            chk_eq("rst_valid", vld[d], 0);
            chk_eq("rst_data", odata[d], 0);
            chk_eq("rst_last", last[d], 0);
            chk_eq("rst_beat_cnt", bcnt[d], 0);
            exq[d].delete();
            beats[d] = 0;
            wait_cnt[d] = 0;
            stall_prev[d] = 1'b0;
            pend_rd[d] = 1'b0;
            return;
        end
        chk_eq("beat_cnt", bcnt[d], beats[d]);
        if (empty[d] || flush[d]) chk_eq("rd_gated", rd_en[d], 0);
        if (stall_prev[d]) begin
            chk_eq("stall_valid", vld[d], 1);
            chk_eq("stall_data", odata[d], stall_data[d]);
        end
        if (vld[d]) begin
            wait_cnt[d] = 0;
            if (exq[d].size() == 0) begin
                chk_eq("spurious_valid", vld[d], 0);
            end else begin
                e = exq[d][0];
                chk_eq("out_data", odata[d], e[7:0]);
                chk_eq("out_last_lane", last[d], e[8]);
            end
            if (first_vld[d] < 0) first_vld[d] = cyc;
        end else begin
            chk_eq("last_without_valid", last[d], 0);
            if (exq[d].size() != 0) begin
                wait_cnt[d]++;
                if (wait_cnt[d] > 1) chk_eq("valid_latency", wait_cnt[d], 1);
            end
        end
        if (vld[d] && ready[d]) begin
            beats[d]++;
            obs[d].push_back(odata[d]);
            obs_lst[d].push_back(last[d]);
            xcyc[d].push_back(cyc);
            if (exq[d].size() != 0) void'(exq[d].pop_front());
        end
        stall_prev[d] = vld[d] && !ready[d] && !flush[d];
        stall_data[d] = odata[d];
        if (rd_en[d]) begin
            rd_pulses[d]++;
            if (first_rd[d] < 0) first_rd[d] = cyc;
            if (fq[d].size() == 0) begin
                chk_eq("rd_on_empty", rd_en[d], 0);
            end else begin
                w = fq[d].pop_front();
                pend_rd[d] = 1'b1;
                pend_word[d] = w;
                for (int l = 0; l < r; l++) exq[d].push_back({(l == r - 1), w[l*8 +: 8]});
            end
        end
        if ((exq[d].size() + r - 1) / r > 2) chk_eq("occupancy", (exq[d].size() + r - 1) / r, 2);
        if (flush[d]) exq[d].delete();
    endtask

    // One clock: inputs already driven; sample, model, then advance to the next negedge.
    task automatic cycle();
        for (int d = 0; d < 2; d++) empty[d] = (fq[d].size() == 0) || force_empty[d];
        #1;
        for (int d = 0; d < 2; d++) model_step(d);
        cyc++;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            fdata[d] = pend_rd[d] ? pend_word[d] : $urandom;
            pend_rd[d] = 1'b0;
        end
    endtask

    task automatic run_until_obs(input int d, input int n, input int budget);
        int k;
        k = 0;
        while (obs[d].size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk_eq("collect_timeout", obs[d].size() >= n, 1);
    endtask

    task automatic clear_obs(input int d);
        obs[d].delete();
        obs_lst[d].delete();
        xcyc[d].delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b0 [2];
        int          written [2];
        int          k;
        logic [31:0] keep;
        n_checks = 0;
        n_fail = 0;
        cyc = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            flush[d] = 0; ready[d] = 0; force_empty[d] = 0; fdata[d] = 0;
            pend_rd[d] = 0; pend_word[d] = 0; beats[d] = 0; wait_cnt[d] = 0;
            rd_pulses[d] = 0; first_rd[d] = -1; first_vld[d] = -1;
            stall_prev[d] = 0; stall_data[d] = 0; empty[d] = 1;
        end
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1'b1;

        // Two words, ready high: eight beats back to back
        fq[0].push_back(32'h03020100);
        fq[0].push_back(32'h07060504);
        ready[0] = 1;
        rd_pulses[0] = 0;
        clear_obs(0);
        run_until_obs(0, 8, 40);
        for (int i = 0; i < 8; i++) if (obs[0].size() > i) begin
            chk_eq("t1_byte", obs[0][i], i);
            chk_eq("t1_last", obs_lst[0][i], (i % 4) == 3);
        end
        if (xcyc[0].size() >= 8) chk_eq("t1_span", xcyc[0][7] - xcyc[0][0], 7);
        chk_eq("t1_rd_pulses", rd_pulses[0], 2);
        chk_eq("t1_beat_cnt", bcnt[0], 8);

        // Backpressure: four words queued, only two reads while stalled
        ready[0] = 0;
        rd_pulses[0] = 0;
        clear_obs(0);
        fq[0].push_back(32'h03020100);
        fq[0].push_back(32'h07060504);
        fq[0].push_back(32'h0B0A0908);
        fq[0].push_back(32'h0F0E0D0C);
        repeat (10) cycle();
        chk_eq("t2_rd_pulses", rd_pulses[0], 2);
        chk_eq("t2_valid_held", vld[0], 1);
        chk_eq("t2_data_held", odata[0], 8'h00);
        ready[0] = 1;
        run_until_obs(0, 16, 60);
        for (int i = 0; i < 16; i++) if (obs[0].size() > i) chk_eq("t2_byte", obs[0][i], i);
        chk_eq("t2_beat_cnt", bcnt[0], 24);

        // RATIO=1: startup latency of two and then no bubbles
        first_rd[1] = -1;
        first_vld[1] = -1;
        clear_obs(1);
        for (int i = 0; i < 16; i++) fq[1].push_back(i);
        ready[1] = 1;
        run_until_obs(1, 16, 40);
        chk_eq("t3_latency", first_vld[1] - first_rd[1], 2);
        if (xcyc[1].size() >= 16) chk_eq("t3_span", xcyc[1][15] - xcyc[1][0], 15);
        for (int i = 0; i < 16; i++) if (obs[1].size() > i) begin
            chk_eq("t3_byte", obs[1][i], i);
            chk_eq("t3_last", obs_lst[1][i], 1);
        end

        // Random ready, sporadic refill, fifo_empty glitching
        for (int d = 0; d < 2; d++) begin
            b0[d] = beats[d];
            written[d] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                ready[d] = $urandom_range(0, 1);
                force_empty[d] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) == 0 && fq[d].size() < 6) begin
                    fq[d].push_back($urandom);
                    written[d] += ratio_of(d);
                end
            end
            cycle();
        end
        for (int d = 0; d < 2; d++) begin
            ready[d] = 1;
            force_empty[d] = 0;
        end
        k = 0;
        while ((fq[0].size() + fq[1].size() + exq[0].size() + exq[1].size()) != 0 && k < 200) begin
            cycle();
            k++;
        end
        chk_eq("t4_drain_timeout", k < 200, 1);
        chk_eq("t4_count_a", bcnt[0] - b0[0], written[0]);
        chk_eq("t4_count_b", bcnt[1] - b0[1], written[1]);

        // Flush with a read in flight, mid-word
        clear_obs(0);
        fq[0].push_back(32'h03020100);
        ready[0] = 1;
        run_until_obs(0, 2, 20);
        ready[0] = 0;
        fq[0].push_back(32'h07060504);
        rd_pulses[0] = 0;
        cycle();
        chk_eq("t5_read_issued", rd_pulses[0], 1);
        keep = beats[0];
        flush[0] = 1;
        cycle();
        flush[0] = 0;
        chk_eq("t5_valid_after_flush", vld[0], 0);
        chk_eq("t5_beat_cnt_kept", bcnt[0], keep);
        clear_obs(0);
        fq[0].push_back(32'h0B0A0908);
        ready[0] = 1;
        run_until_obs(0, 4, 20);
        repeat (4) cycle();
        chk_eq("t5_beats_after_flush", obs[0].size(), 4);
        for (int i = 0; i < 4; i++) if (obs[0].size() > i) chk_eq("t5_byte", obs[0][i], 8 + i);

        // Asynchronous reset at lane 2
        clear_obs(0);
        fq[0].push_back(32'h13121110);
        fq[0].push_back(32'h17161514);
        ready[0] = 1;
        run_until_obs(0, 2, 20);
        ready[0] = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("t6_async_valid", vld[0], 0);
        chk_eq("t6_async_data", odata[0], 0);
        chk_eq("t6_async_last", last[0], 0);
        chk_eq("t6_async_beat_cnt", bcnt[0], 0);
        cycle();
        cycle();
        rst_n = 1'b1;
        clear_obs(0);
        fq[0].push_back(32'h1B1A1918);
        ready[0] = 1;
        run_until_obs(0, 4, 20);
        for (int i = 0; i < 4; i++) if (obs[0].size() > i) begin
            chk_eq("t6_byte", obs[0][i], 8'h18 + i);
            chk_eq("t6_last", obs_lst[0][i], i == 3);
        end
        chk_eq("t6_beat_cnt", bcnt[0], 4);
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_fifo_unpack_reader.md
Name: iob_fifo_unpack_reader

Overview:
- Read-side engine for the synchronous FIFOs (symmetric and asymmetric).
- Pulls DATA_W words from the FIFO read port, which has a 1-cycle registered read latency.
- Splits each word into RATIO = DATA_W/OUT_W lanes, lowest lane first, and presents them on a valid/ready stream.
- Sits between a FIFO and any stream consumer (serialiser, DMA, UART TX path).

Parameters:
- DATA_W, 32, FIFO read-word width; must be an integer multiple of OUT_W.
- OUT_W, 8, output stream beat width.
- CNT_W, 32, width of the beat counter.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of buffered data and lane state.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_en  out  1  FIFO read strobe.
- fifo_data  in  DATA_W  FIFO read data; valid the cycle after fifo_read_en.
- out_valid  out  1  output beat available.
- out_ready  in  1  consumer accepts beat.
- out_data  out  OUT_W  output beat.
- out_last_lane  out  1  current beat is the last lane (RATIO-1) of its word.
- beat_cnt  out  CNT_W  accepted-beat counter; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, asynchronous):
  - fifo_read_en=0, out_valid=0, out_data=0, out_last_lane=0, beat_cnt=0.
  - Buffer count=0, lane=0, in-flight flag=0.
- Buffer: 2-entry word queue (head/tail registers) plus a 1-bit in-flight flag set the cycle after fifo_read_en.
- Read request: fifo_read_en = !fifo_empty && !flush && (count + inflight + pop_this_cycle_credit) < 2.
  - Buffer occupancy plus in-flight reads never exceeds 2; no FIFO word is ever dropped.
- Capture: the cycle after fifo_read_en=1, fifo_data is written into the buffer, unless a flush occurred in that interval. A flush discards that in-flight word.
- Output (combinational from registers):
  - out_valid = (count>0).
  - out_data = head[lane*OUT_W +: OUT_W].
  - out_last_lane = out_valid && (lane==RATIO-1).
- Handshake:
  - A beat transfers when out_valid && out_ready.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - On transfer: beat_cnt+1. If lane==RATIO-1, pop head and set lane=0; else lane+1.
- Simultaneous pop and capture in the same cycle: count unchanged, the new word goes behind the remaining entry. Ordering is strictly FIFO.
- RATIO=1: lane is constant 0, out_last_lane=out_valid, and every transfer pops.
- Empty FIFO: no read is issued. out_valid drops after the last lane of the last buffered word.
- fifo_empty toggling during an in-flight read has no effect on the captured word.
- flush:
  - Next edge: count=0, lane=0, in-flight cleared. beat_cnt is not cleared.
  - fifo_read_en is forced 0 during the flush cycle.
- Mid-word reset or flush abandons the remaining lanes of that word.
- Throughput: with a full FIFO and out_ready=1, the block sustains one beat per cycle for any RATIO>=1.
  - Reads are issued early enough that the RATIO=1 stream has no bubbles after the initial 2-cycle startup latency (fifo_read_en at cycle 0, first out_valid at cycle 2).
- Illegal configuration: DATA_W % OUT_W != 0 fails elaboration via a generate-time check.

Decomposition:
- Shared package/header holds:
  - RATIO = DATA_W/OUT_W.
  - LANE_W = clog2(RATIO), minimum 1.
  - FIFO read latency constant = 1.
  - Lane ordering constant (low lane first), shared with the asymmetric FIFO write-side packer.
- One natural sub-module, iob_word_skid2: the 2-entry word queue with push/pop/count and flush.
- Lane counter, read-credit logic and beat counter live in the top module.

Test Plan:
- DATA_W=32, OUT_W=8. FIFO preloaded with 0x03020100 and 0x07060504, out_ready=1 -> beats 00,01,…,07 on consecutive cycles. out_last_lane high on beats 03 and 07. beat_cnt=8. fifo_read_en issued exactly twice.
- Same setup plus 2 more words, out_ready=0 for 10 cycles -> exactly 2 fifo_read_en pulses and out_data stable at 00. Release ready -> 16 in-order bytes, no loss or duplication.
- RATIO=1 (DATA_W=OUT_W=8), 16 words 0..15 in FIFO, ready=1 -> first out_valid 2 cycles after the first fifo_read_en, then 16 back-to-back beats 0..15.
- Random out_ready (50%) plus FIFO refilled sporadically with fifo_empty toggling -> output byte sequence equals the written byte stream and beat_cnt equals the byte count.
- flush asserted after beat 01 with a read in flight -> next edge out_valid=0 and the in-flight word is discarded. The following FIFO word 0x0B0A0908 yields 08,09,0A,0B. beat_cnt is unchanged by the flush.
- rst low asynchronously mid-word (lane=2) -> all outputs 0 immediately. After release, the next word restarts at lane 0.
